bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Time-multiplexed driver for a six-digit common-anode 7-segment display, consuming the six BCD time digits (sec0..hour1) produced by the digital clock counter. Takes a coherent per-frame snapshot of the digits, scans one digit per slot with a one-cycle anti-ghosting blank, decodes BCD to active-low segments, and lights separator dots. Sits between the clock core and the board's display pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_LZ, 1: when 1, a zero hour1 digit is blanked.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- sec0, sec1, min0, min1, hour0, hour1  in  4 each  BCD digits from the clock core; values 10–15 are legal inputs (shown as dash).
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- DP  out  1  decimal point, active-low, registered.
- AN  out  6  digit enables, active-low one-hot, registered; AN[0]=sec0 … AN[5]=hour1.

## Operation
- State: prescaler cnt (0..SCAN_DIV-1), digit index idx (0..5), 24-bit snapshot snap, flag first.
- Reset: cnt=0, idx=0, snap=0, first=1; SEG=7'h7F, DP=1, AN=6'h3F.
- Every non-reset edge: cnt increments; at cnt==SCAN_DIV-1, cnt←0 and idx←(idx==5 ? 0 : idx+1).
- Snapshot: snap←{hour1,hour0,min1,min0,sec1,sec0} on the first non-reset edge (first←0) and on every wrap edge (cnt==SCAN_DIV-1 and idx==5). Inputs are never sampled at any other time; mid-frame input changes are invisible until the next frame.
- Digit order idx 0..5: sec0, sec1, min0, min1, hour0, hour1.
- Output function of the pre-edge (cnt, idx, snap), registered:
  - cnt==0 → blank slot: AN=6'h3F, SEG=7'h7F, DP=1.
  - idx==5, BLANK_LZ==1, snap hour1==0 → AN=6'h3F, SEG=7'h7F, DP=1.
  - otherwise AN = all ones except bit idx = 0; SEG = decode(digit); DP=0 when idx is 2 or 4, else 1.
- Decode (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex); 10–15→3F (segment g only, dash).

## Timing
- Output latency: one cycle from state to pins.
- After RESET deasserts: edge 1 blank (cnt was 0) and snapshot loaded; edges 2..SCAN_DIV show sec0; edge SCAN_DIV+1 blank; then sec1, etc.
- Each slot: 1 blank cycle + SCAN_DIV-1 lit cycles; frame = 6·SCAN_DIV cycles.
- At most one AN bit low at any cycle; never two digits lit simultaneously, including across slot boundaries.
- RESET mid-frame: on that edge all outputs go to reset values and the scan restarts at idx 0 with a fresh snapshot on the next non-reset edge.
- Input change coinciding with a wrap edge: new value captured into the snapshot.

## Structure
- Shared package: SEG_BLANK (7'h7F), SEG_DASH (7'h3F), digit-index constants, the 10-entry segment pattern table.
- One sub-module: bcd_to_seg7 (combinational 4-bit BCD → 7-bit active-low pattern, dash for invalid). Scanner, snapshot and output registers live in the top.

## Test plan
- Reset: hold RESET 3 cycles with arbitrary inputs → SEG=7F, DP=1, AN=3F each cycle.
- Basic scan, SCAN_DIV=4, inputs 1 2:3 4:5 6 (hour1=1,hour0=2,min1=3,min0=4,sec1=5,sec0=6) → after release, edge 1 blank, edges 2–4 AN=3E SEG=02, edge 5 blank, edges 6–8 AN=3D SEG=12, …, min0 slot DP=0, hour0 slot DP=0 SEG=24, hour1 slot AN=1F SEG=79; sequence repeats every 24 cycles.
- Leading zero: hour1=0, BLANK_LZ=1 → hour1 slot AN=3F SEG=7F; with BLANK_LZ=0 → AN=1F SEG=40.
- Snapshot coherence: change sec0 6→7 mid-frame while scanning min1 → current frame unchanged; next frame sec0 slot SEG=78.
- Invalid BCD: min1=4'hC → min1 slot SEG=3F, AN=37.
- Reset mid-frame during hour0 slot → next edge reset values; scan restarts at sec0 after one blank cycle; no cycle with two AN bits low across the whole run (continuous assertion).

Source files
------------

// File: rtl/bcd_display_scanner_pkg.sv
// bcd_display_scanner_pkg: shared segment patterns and digit indices for the display scanner
package bcd_display_scanner_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [5:0] AN_OFF = 6'h3F;
    localparam logic [2:0] IDX_SEC0 = 3'd0;
    localparam logic [2:0] IDX_SEC1 = 3'd1;
    localparam logic [2:0] IDX_MIN0 = 3'd2;
    localparam logic [2:0] IDX_MIN1 = 3'd3;
    localparam logic [2:0] IDX_HOUR0 = 3'd4;
    localparam logic [2:0] IDX_HOUR1 = 3'd5;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g..a} pattern, dash for non-decimal codes
module bcd_to_seg7
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = (bcd < 4'd10) ? SEG_TABLE[bcd] : SEG_DASH;
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: frame-snapshotted six-digit 7-segment scanner with per-slot blanking
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] sec0,
    input  logic [3:0] sec1,
    input  logic [3:0] min0,
    input  logic [3:0] min1,
    input  logic [3:0] hour0,
    input  logic [3:0] hour1,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [5:0] AN
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic          first;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic          last;
    logic          blank;

    assign digit = snap[{idx, 2'b00} +: 4];
    assign last  = cnt == CNT_LAST;
    // the first cycle of every slot stays dark so the previous digit never ghosts into the next
    assign blank = cnt == '0 || (BLANK_LZ && idx == IDX_HOUR1 && snap[23:20] == 4'd0);

    bcd_to_seg7 u_dec (
        .bcd(digit),
        .seg(seg_dec)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt   <= '0;
            idx   <= IDX_SEC0;
            snap  <= '0;
            first <= 1'b1;
            SEG   <= SEG_BLANK;
            DP    <= 1'b1;
            AN    <= AN_OFF;
        end else begin
            cnt   <= last ? '0 : cnt + 1'b1;
            idx   <= last ? (idx == IDX_HOUR1 ? IDX_SEC0 : idx + 3'd1) : idx;
            first <= 1'b0;
            if (first || (last && idx == IDX_HOUR1))
                snap <= {hour1, hour0, min1, min0, sec1, sec0};
            SEG   <= blank ? SEG_BLANK : seg_dec;
            DP    <= blank ? 1'b1 : !(idx == IDX_MIN0 || idx == IDX_HOUR0);
            AN    <= blank ? AN_OFF : ~(6'b1 << idx);
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed scan, snapshot, leading-zero, invalid-BCD and mid-frame reset checks
module tb_bcd_display_scanner;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] sec0 = 4'd9, sec1 = 4'd9, min0 = 4'd9, min1 = 4'd9, hour0 = 4'd9, hour1 = 4'd9;
    logic [6:0] SEG, SEG_n;
    logic       DP, DP_n;
    logic [5:0] AN, AN_n;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
        .hour0(hour0), .hour1(hour1), .SEG(SEG), .DP(DP), .AN(AN)
    );

    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nolz (
        .CLK(CLK), .RESET(RESET), .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
        .hour0(hour0), .hour1(hour1), .SEG(SEG_n), .DP(DP_n), .AN(AN_n)
    );

    // no two digits may ever be enabled together
    always @(negedge CLK) begin
        checks++;
        assert ($countones(~AN) <= 1 && $countones(~AN_n) <= 1) else begin
            errors++;
            $error("FAIL one_hot: observed AN=%h AN_n=%h expected at most one low bit", AN, AN_n);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [5:0] an, input logic [6:0] seg,
                              input logic dp, input logic lz_blank);
        chk({tag, "_an"}, 7'(AN), lz_blank ? 7'h3F : 7'(an));
        chk({tag, "_seg"}, SEG, lz_blank ? 7'h7F : seg);
        chk({tag, "_dp"}, 7'(DP), lz_blank ? 7'd1 : 7'(dp));
        chk({tag, "_an_n"}, 7'(AN_n), 7'(an));
        chk({tag, "_seg_n"}, SEG_n, seg);
        chk({tag, "_dp_n"}, 7'(DP_n), 7'(dp));
    endtask

    task automatic slot(input string tag, input logic [5:0] an, input logic [6:0] seg,
                        input logic dp, input logic lz_blank);
        tick();
        expect_out({tag, "_blank"}, 6'h3F, 7'h7F, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out(tag, an, seg, dp, lz_blank);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("reset", 6'h3F, 7'h7F, 1'b1, 1'b0);
        end
        {hour1, hour0, min1, min0, sec1, sec0} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        RESET = 1'b0;
        // frame 1
        slot("f1_sec0", 6'h3E, 7'h02, 1'b1, 1'b0);
        slot("f1_sec1", 6'h3D, 7'h12, 1'b1, 1'b0);
        slot("f1_min0", 6'h3B, 7'h19, 1'b0, 1'b0);
        slot("f1_min1", 6'h37, 7'h30, 1'b1, 1'b0);
        slot("f1_hour0", 6'h2F, 7'h24, 1'b0, 1'b0);
        slot("f1_hour1", 6'h1F, 7'h79, 1'b1, 1'b0);
        // frame 2: inputs change mid-frame, display must hold the old snapshot
        slot("f2_sec0", 6'h3E, 7'h02, 1'b1, 1'b0);
        slot("f2_sec1", 6'h3D, 7'h12, 1'b1, 1'b0);
        slot("f2_min0", 6'h3B, 7'h19, 1'b0, 1'b0);
        tick();
        expect_out("f2_min1_blank", 6'h3F, 7'h7F, 1'b1, 1'b0);
        sec0 = 4'd7;
        hour1 = 4'd0;
        min1 = 4'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("f2_min1", 6'h37, 7'h30, 1'b1, 1'b0);
        end
        slot("f2_hour0", 6'h2F, 7'h24, 1'b0, 1'b0);
        slot("f2_hour1", 6'h1F, 7'h79, 1'b1, 1'b0);
        // frame 3: new snapshot, invalid min1, zero hour1
        slot("f3_sec0", 6'h3E, 7'h78, 1'b1, 1'b0);
        slot("f3_sec1", 6'h3D, 7'h12, 1'b1, 1'b0);
        slot("f3_min0", 6'h3B, 7'h19, 1'b0, 1'b0);
        slot("f3_min1", 6'h37, 7'h3F, 1'b1, 1'b0);
        slot("f3_hour0", 6'h2F, 7'h24, 1'b0, 1'b0);
        slot("f3_hour1", 6'h1F, 7'h40, 1'b1, 1'b1);
        // frame 4: reset in the middle of the hour0 slot
        slot("f4_sec0", 6'h3E, 7'h78, 1'b1, 1'b0);
        slot("f4_sec1", 6'h3D, 7'h12, 1'b1, 1'b0);
        slot("f4_min0", 6'h3B, 7'h19, 1'b0, 1'b0);
        slot("f4_min1", 6'h37, 7'h3F, 1'b1, 1'b0);
        tick();
        expect_out("f4_hour0_blank", 6'h3F, 7'h7F, 1'b1, 1'b0);
        tick();
        expect_out("f4_hour0", 6'h2F, 7'h24, 1'b0, 1'b0);
        RESET = 1'b1;
        tick();
        expect_out("midreset", 6'h3F, 7'h7F, 1'b1, 1'b0);
        RESET = 1'b0;
        slot("r_sec0", 6'h3E, 7'h78, 1'b1, 1'b0);
        slot("r_sec1", 6'h3D, 7'h12, 1'b1, 1'b0);
        slot("r_min0", 6'h3B, 7'h19, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
